nn_matvec_engine: RTL

//  Parametrised NxN signed matrix-vector multiply engine for the NN accelerator path. Next generation of the 4x4 MAC array.

---
 rtl/nn_matvec_engine.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/nn_matvec_engine.sv
// NxN signed matrix-vector multiply engine: y = W*x, one column per cycle through N MACs,
// with per-step saturation, sticky overflow flag, optional ReLU and valid/ready on both sides.
module nn_matvec_engine #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int ACC_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  w_we,
    input  logic [$clog2(N)-1:0]  w_row,
    input  logic [$clog2(N)-1:0]  w_col,
    input  logic signed [DW-1:0]  w_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DW-1:0]       in_vec,
    input  logic                  relu_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*ACC_W-1:0]    out_vec,
    output logic                  sat_flag,
    output logic                  busy
);
    localparam int IW = $clog2(N);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t state, next_state;

    logic signed [DW-1:0]    w_mem [N][N];
    logic signed [DW-1:0]    x_cap [N];
    logic signed [ACC_W-1:0] acc   [N];
    logic [IW-1:0]           col;
    logic                    relu_cap;
    logic                    sat_acc;

    logic signed [2*DW-1:0]  prod     [N];
    logic signed [ACC_W-1:0] prod_ext [N];
    logic signed [ACC_W-1:0] acc_next [N];
    logic [N-1:0]            step_sat;

    logic accept, take, w_in_range;

    // Returns {clamped, value}; the sum is formed one bit wider so overflow is visible.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, ACC_MIN} : {1'b1, ACC_MAX};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    function automatic logic signed [ACC_W-1:0] relu_clip(input logic en,
                                                          input logic signed [ACC_W-1:0] v);
        return (en && v[ACC_W-1]) ? '0 : v;
    endfunction

    generate
        if ((1 << IW) == N) begin : g_pow2
            assign w_in_range = 1'b1;
        end else begin : g_npow2
            assign w_in_range = (int'(w_row) < N) && (int'(w_col) < N);
        end
    endgenerate

    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready;
    assign busy   = (state != IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = COMPUTE;
            COMPUTE: if (col == IW'(N-1)) next_state = DONE;
            DONE:    if (take) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // in_ready is registered so it stays low for as long as reset is held
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            in_ready <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state == IDLE);
        end
    end

    // MAC stage: all rows consume column col of W and element col of x
    always_comb begin
        for (int r = 0; r < N; r++) begin
            prod[r] = (2*DW)'(w_mem[r][col]) * (2*DW)'(x_cap[col]);
            prod_ext[r] = ACC_W'(prod[r]);
            {step_sat[r], acc_next[r]} = sat_add(acc[r], prod_ext[r]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) w_mem[r][c] <= '0;
                x_cap[r] <= '0;
                acc[r]   <= '0;
            end
            col       <= '0;
            relu_cap  <= 1'b0;
            sat_acc   <= 1'b0;
            out_valid <= 1'b0;
            out_vec   <= '0;
            sat_flag  <= 1'b0;
        end else begin
            if (w_we && w_in_range && state != COMPUTE)
                w_mem[w_row][w_col] <= w_data;
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < N; i++) begin
                            x_cap[i] <= in_vec[i*DW +: DW];
                            acc[i]   <= '0;
                        end
                        relu_cap <= relu_en;
                        sat_acc  <= 1'b0;
                        col      <= '0;
                    end
                end
                COMPUTE: begin
                    for (int r = 0; r < N; r++) acc[r] <= acc_next[r];
                    sat_acc <= sat_acc | (|step_sat);
                    col     <= col + 1'b1;
                end
                DONE: begin
                    // Output stage: results are registered once, then held until the next DONE
                    if (!out_valid) begin
                        for (int r = 0; r < N; r++)
                            out_vec[r*ACC_W +: ACC_W] <= relu_clip(relu_cap, acc[r]);
                        sat_flag  <= sat_acc;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
